alu_operand_seq: RTL and testbench

Operand-entry sequencer that sits directly upstream of the ALU on the FPGA test board. It turns one 17-bit switch bank and two push-buttons into a stepped entry sequence: operand A, then operand B, then opcode. It drives the ALU's `porta`, `portb` and `aluop`, then captures `portout` and the flags into a result register for the display stage. The button inputs are synchronized and debounced internally.

---
 rtl/alu_operand_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_operand_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_seq.sv
// Operand-entry sequencer in front of the board ALU: steps A, B and opcode in from
// the switch bank on debounced button presses, then captures the ALU result and flags.

module alu_operand_seq_debounce #(
  parameter int CYCLES = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept on the edge where the count would reach CYCLES, so a clean edge is seen 2 + CYCLES cycles later
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_d;

endmodule

module alu_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [16:0] sw,
  input  logic        step_n,
  input  logic        clear_n,
  output logic [31:0] porta,
  output logic [31:0] portb,
  output logic [3:0]  aluop,
  input  logic [31:0] alu_portout,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  output logic [31:0] result,
  output logic        z_flag,
  output logic        n_flag,
  output logic        v_flag,
  output logic        result_valid,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_GET_A  = 3'd0;
  localparam logic [2:0] ST_GET_B  = 3'd1;
  localparam logic [2:0] ST_GET_OP = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_SHOW   = 3'd4;

  logic        stepEv, clearEv;
  logic [31:0] extSw;

  logic [2:0]  state_q, state_d;
  logic [31:0] porta_q, porta_d;
  logic [31:0] portb_q, portb_d;
  logic [3:0]  aluop_q, aluop_d;
  logic [31:0] result_q, result_d;
  logic        z_q, z_d, n_q, n_d, v_q, v_d;
  logic        valid_q, valid_d;

  alu_operand_seq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .CLK     (CLK),
    .nRST    (nRST),
    .btn_n_i (step_n),
    .press_o (stepEv)
  );

  alu_operand_seq_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .CLK     (CLK),
    .nRST    (nRST),
    .btn_n_i (clear_n),
    .press_o (clearEv)
  );

  // sw[16] selects sign extension, which only matters when sw[15] is set
  assign extSw = {{16{sw[16] & sw[15]}}, sw[15:0]};

  always_comb begin
    state_d  = state_q;
    porta_d  = porta_q;
    portb_d  = portb_q;
    aluop_d  = aluop_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    valid_d  = valid_q;
    if (clearEv) begin
      state_d  = ST_GET_A;
      porta_d  = '0;
      portb_d  = '0;
      aluop_d  = '0;
      result_d = '0;
      z_d      = 1'b0;
      n_d      = 1'b0;
      v_d      = 1'b0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_GET_A: begin
          if (stepEv) begin
            porta_d = extSw;
            state_d = ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (stepEv) begin
            portb_d = extSw;
            state_d = ST_GET_OP;
          end
        end
        ST_GET_OP: begin
          if (stepEv) begin
            aluop_d = sw[3:0];
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_d = alu_portout;
          z_d      = alu_z;
          n_d      = alu_n;
          v_d      = alu_v;
          valid_d  = 1'b1;
          state_d  = ST_SHOW;
        end
        ST_SHOW: begin
          if (stepEv) begin
            valid_d = 1'b0;
            state_d = ST_GET_A;
          end
        end
        default: state_d = ST_GET_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_GET_A;
      porta_q  <= '0;
      portb_q  <= '0;
      aluop_q  <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      porta_q  <= porta_d;
      portb_q  <= portb_d;
      aluop_q  <= aluop_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      valid_q  <= valid_d;
    end
  end

  assign porta        = porta_q;
  assign portb        = portb_q;
  assign aluop        = aluop_q;
  assign result       = result_q;
  assign z_flag       = z_q;
  assign n_flag       = n_q;
  assign v_flag       = v_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq with a small behavioural ALU attached; result captures
// are matched against a queue of expected results filled as each opcode is entered.

module tb_alu_operand_seq;

  logic        CLK;
  logic        nRST;
  logic [16:0] sw;
  logic        step_n, clear_n;
  logic [31:0] porta, portb, result;
  logic [3:0]  aluop;
  logic [31:0] aluOut;
  logic        aluZ, aluN, aluV;
  logic        z_flag, n_flag, v_flag, result_valid;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] swA;
    logic [16:0] swB;
    logic [3:0]  op;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expResult;
    logic        expZ;
    logic        expN;
    logic        expV;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        v;
  } sb_t;

  vec_t vecs[6];
  sb_t  sbQueue[$];

  alu_operand_seq #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .sw           (sw),
    .step_n       (step_n),
    .clear_n      (clear_n),
    .porta        (porta),
    .portb        (portb),
    .aluop        (aluop),
    .alu_portout  (aluOut),
    .alu_z        (aluZ),
    .alu_n        (aluN),
    .alu_v        (aluV),
    .result       (result),
    .z_flag       (z_flag),
    .n_flag       (n_flag),
    .v_flag       (v_flag),
    .result_valid (result_valid),
    .state        (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the board ALU: AND, OR, ADD, SUB, XOR
  always_comb begin
    aluOut = '0;
    aluV   = 1'b0;
    case (aluop)
      4'h0: aluOut = porta & portb;
      4'h1: aluOut = porta | portb;
      4'h2: begin
        aluOut = porta + portb;
        aluV   = (porta[31] == portb[31]) && (aluOut[31] != porta[31]);
      end
      4'h3: begin
        aluOut = porta - portb;
        aluV   = (porta[31] != portb[31]) && (aluOut[31] != porta[31]);
      end
      4'h4: aluOut = porta ^ portb;
      default: aluOut = '0;
    endcase
  end
  assign aluZ = (aluOut == 32'd0);
  assign aluN = aluOut[31];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One button press: hold low long enough to debounce, then release and let the release settle
  task automatic applyStimulus(input logic [16:0] swVal, input logic doStep, input logic doClear);
    sw = swVal;
    if (doStep)  step_n  = 1'b0;
    if (doClear) clear_n = 1'b0;
    repeat (10) @(negedge CLK);
    step_n  = 1'b1;
    clear_n = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  initial begin : monitor
    sb_t  expItem;
    logic prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge CLK);
      if (result_valid && !prevValid) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard: unexpected capture %h, expected none", result);
        end else begin
          expItem = sbQueue.pop_front();
          checkOutput("sb_result", result, expItem.res);
          checkOutput("sb_z", {31'b0, z_flag}, {31'b0, expItem.z});
          checkOutput("sb_n", {31'b0, n_flag}, {31'b0, expItem.n});
          checkOutput("sb_v", {31'b0, v_flag}, {31'b0, expItem.v});
        end
      end
      prevValid = result_valid;
    end
  end

  initial begin
    vecs[0] = '{17'h00005, 17'h00003, 4'h2, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{17'h1FFFF, 17'h0FFFF, 4'h2, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{17'h00003, 17'h00003, 4'h3, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{17'h18000, 17'h00001, 4'h3, 32'hFFFF8000, 32'h00000001, 32'hFFFF7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{17'h08000, 17'h10005, 4'h2, 32'h00008000, 32'h00000005, 32'h00008005, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{17'h0F0F0, 17'h0FF00, 4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1'b0};

    nRST    = 1'b0;
    sw      = '0;
    step_n  = 1'b1;
    clear_n = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rst_state", {29'b0, state}, 32'd0);
    checkOutput("rst_porta", porta, 32'd0);
    checkOutput("rst_portb", portb, 32'd0);
    checkOutput("rst_aluop", {28'b0, aluop}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_flags", {29'b0, z_flag, n_flag, v_flag}, 32'd0);
    checkOutput("rst_valid", {31'b0, result_valid}, 32'd0);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].swA, 1'b1, 1'b0);
      checkOutput("vec_stateB", {29'b0, state}, 32'd1);
      checkOutput("vec_porta", porta, vecs[i].expA);
      applyStimulus(vecs[i].swB, 1'b1, 1'b0);
      checkOutput("vec_stateOp", {29'b0, state}, 32'd2);
      checkOutput("vec_portb", portb, vecs[i].expB);
      sbQueue.push_back('{vecs[i].expResult, vecs[i].expZ, vecs[i].expN, vecs[i].expV});
      applyStimulus({13'b0, vecs[i].op}, 1'b1, 1'b0);
      checkOutput("vec_aluop", {28'b0, aluop}, {28'b0, vecs[i].op});
      checkOutput("vec_stateShow", {29'b0, state}, 32'd4);
      checkOutput("vec_valid", {31'b0, result_valid}, 32'd1);
      checkOutput("vec_showResult", result, vecs[i].expResult);
      applyStimulus(17'h00000, 1'b1, 1'b0);
      checkOutput("exit_state", {29'b0, state}, 32'd0);
      checkOutput("exit_valid", {31'b0, result_valid}, 32'd0);
      checkOutput("exit_porta", porta, vecs[i].expA);
    end

    // Short glitch must be ignored
    sw = 17'h00005;
    step_n = 1'b0;
    repeat (3) @(negedge CLK);
    step_n = 1'b1;
    repeat (15) @(negedge CLK);
    checkOutput("glitch_state", {29'b0, state}, 32'd0);

    // Long hold: advance exactly 6 cycles after the falling edge, and only once
    step_n = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("hold_early", {29'b0, state}, 32'd0);
    @(negedge CLK);
    checkOutput("hold_advance", {29'b0, state}, 32'd1);
    checkOutput("hold_porta", porta, 32'h5);
    repeat (34) @(negedge CLK);
    step_n = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("hold_once", {29'b0, state}, 32'd1);

    applyStimulus(17'h00003, 1'b1, 1'b0);
    checkOutput("clr_pre", {29'b0, state}, 32'd2);
    applyStimulus(17'h00000, 1'b0, 1'b1);
    checkOutput("clr_state", {29'b0, state}, 32'd0);
    checkOutput("clr_porta", porta, 32'd0);
    checkOutput("clr_portb", portb, 32'd0);
    checkOutput("clr_aluop", {28'b0, aluop}, 32'd0);
    checkOutput("clr_result", result, 32'd0);
    checkOutput("clr_valid", {31'b0, result_valid}, 32'd0);

    // Step and clear pressed together: clear wins, nothing loaded
    applyStimulus(17'h00005, 1'b1, 1'b0);
    applyStimulus(17'h00007, 1'b1, 1'b1);
    checkOutput("both_state", {29'b0, state}, 32'd0);
    checkOutput("both_porta", porta, 32'd0);
    checkOutput("both_portb", portb, 32'd0);

    applyStimulus(17'h00001, 1'b1, 1'b0);
    applyStimulus(17'h00002, 1'b1, 1'b0);
    sw = 17'h00002;
    step_n = 1'b0;
    repeat (6) @(negedge CLK);
    checkOutput("exec_state", {29'b0, state}, 32'd3);
    checkOutput("exec_valid", {31'b0, result_valid}, 32'd0);
    nRST = 1'b0;
    #1;
    checkOutput("rstExec_state", {29'b0, state}, 32'd0);
    checkOutput("rstExec_result", result, 32'd0);
    checkOutput("rstExec_valid", {31'b0, result_valid}, 32'd0);
    checkOutput("rstExec_porta", porta, 32'd0);
    step_n = 1'b1;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (10) @(negedge CLK);
    checkOutput("postRst_state", {29'b0, state}, 32'd0);
    checkOutput("postRst_valid", {31'b0, result_valid}, 32'd0);

    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
